dds_wave_gen: RTL
=================

Name: dds_wave_gen

Overview:
- Parametrised phase-accumulator (DDS) oscillator; successor to the fixed triangle generator in the synth voice path.
- Produces saw, triangle or variable-duty square waves in offset-binary, centred at midscale, with amplitude scaling.
- Retunes and changes shape glitch-free at waveform wrap.
- Drives the voice mixer once per sample tick (20 kHz); one-cycle wrap pulse available for sync and envelope retrigger.

Parameters:
PHASE_W, 16, phase accumulator and frequency increment width
OUT_W, 8, output sample width (unsigned, midscale = 2^(OUT_W-1))
AMP_W, 7, amplitude width; full scale = 2^AMP_W-1

Ports:
clk  in  1  system clock
rst  in  1  reset
sample_tick  in  1  one-clk strobe per audio sample
en  in  1  oscillator run enable
mode  in  2  00 saw, 01 triangle, 10 square, 11 reserved/noise
freq_inc  in  PHASE_W  phase increment per tick; period = 2^PHASE_W/freq_inc ticks
amplitude  in  AMP_W  output scale
duty  in  OUT_W  square high-threshold
out  out  OUT_W  registered sample
wrap  out  1  one-clk pulse on phase overflow

Interface: one clock; reset is asynchronous and active-high. Clock is clk, reset is rst.

Behaviour:
- Reset values:
  - phase = 0, inc_act = 0, mode_act = 00, wrap = 0.
  - out = 2^(OUT_W-1).
  - rst dominates every other input.
- State: phase, inc_act and mode_act registers; updates occur only on clk edges with sample_tick = 1.
- en = 0 on a tick:
  - phase <= 0; inc_act <= freq_inc; mode_act <= mode.
  - out <= MID; wrap <= 0.
- en = 1 on a tick:
  - sum = phase + inc_act, computed PHASE_W+1 bits wide; phase <= sum[PHASE_W-1:0].
  - Carry sum[PHASE_W] = 1: wrap <= 1 for exactly that clk; inc_act <= freq_inc; mode_act <= mode.
  - inc_act == 0: inc_act <= freq_inc on every tick, so a stalled oscillator never locks up.
- Non-tick clocks: all state holds; wrap <= 0.
- Output latency: out is updated on the same edge as phase and is computed from the pre-update phase. It is valid one clk after the tick edge.
- Shape, with u an unsigned OUT_W-bit value:
  - saw: u = phase[PHASE_W-1 -: OUT_W].
  - triangle: t = phase[PHASE_W-2 -: OUT_W]; u = phase MSB ? ~t : t.
  - square: u = (phase[PHASE_W-1 -: OUT_W] < duty) ? all-ones : 0.
  - mode 11 without the macro: u = MID.
- Scaling:
  - s = u - MID, signed OUT_W bits.
  - scaled = (s * amplitude) >>> AMP_W, signed arithmetic with a full-width product.
  - out = scaled + MID. No overflow is possible.
- Boundaries:
  - amplitude = 0 gives out = MID.
  - duty = 0 gives a constant low level; duty = MID gives 50 %.
  - freq_inc, mode and duty changes: freq_inc and mode take effect only at the next wrap, or immediately while en = 0 or inc_act == 0. duty and amplitude take effect on the next tick.
  - Async rst mid-cycle: outputs return to reset values immediately; the next tick restarts from phase 0.

Optional Feature:
- Macro: DDS_NOISE_EN.
- Defined:
  - Adds a 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 at rst).
  - The LFSR steps on every tick with en = 1; mode 11 gives u = lfsr[OUT_W-1:0].
  - The LFSR reseeds to 16'hACE1 on each wrap, so noise timbre repeats per period.
- Undefined: no LFSR logic; mode 11 outputs MID.

Test Plan:
- Defaults; rst pulse mid-run -> out = 128, wrap = 0 immediately; first tick afterwards gives out from phase 0.
- saw, freq_inc = 16'h0100, amplitude = 127, en = 1:
  - out = 1 at phase 0, rising by about 1 per tick, 254 at phase 16'hFF00.
  - wrap is high for one clk every 256 ticks.
- triangle, same settings:
  - out = 1 at phase 0, 254 at phase 16'h7F80.
  - out = 254 at 16'h8000, then falling to 1 at 16'hFF80.
- square, duty = 64, amplitude = 127 -> out = 254 for 64 ticks, then 1 for 192 ticks, per period.
- Change freq_inc 16'h0100 -> 16'h0200 at tick 100:
  - the next wrap still occurs at tick 256;
  - the following wraps occur every 128 ticks.
- freq_inc = 0 then 16'h0100 with en = 1 -> the new increment is accepted on the next tick with no wrap required. amplitude = 0 -> out stays 128 in all modes.

Source files
------------

// File: rtl/dds_wave_gen_if.sv
// Control/sample bus of the DDS oscillator.
// The master side (voice controller or bench) drives tuning and shape
// controls; the slave side (oscillator) returns the sample and wrap pulse.
interface dds_wave_gen_if #(
    parameter int PHASE_W = 16,
    parameter int OUT_W   = 8,
    parameter int AMP_W   = 7
);
    logic               sample_tick;
    logic               en;
    logic [1:0]         mode;
    logic [PHASE_W-1:0] freq_inc;
    logic [AMP_W-1:0]   amplitude;
    logic [OUT_W-1:0]   duty;
    logic [OUT_W-1:0]   out;
    logic               wrap;

    modport master (
        output sample_tick, en, mode, freq_inc, amplitude, duty,
        input  out, wrap
    );

    modport slave (
        input  sample_tick, en, mode, freq_inc, amplitude, duty,
        output out, wrap
    );
endinterface

// File: rtl/dds_wave_gen.sv
// Phase-accumulator oscillator: saw / triangle / variable-duty square in
// offset binary around midscale, with amplitude scaling. Frequency and shape
// are latched only at phase wrap (or while stopped / stalled) so retuning is
// glitch-free. Optional macro DDS_NOISE_EN adds an LFSR noise source on
// mode 11; without it mode 11 outputs midscale.
module dds_wave_gen #(
    parameter int PHASE_W = 16,
    parameter int OUT_W   = 8,
    parameter int AMP_W   = 7
) (
    input  logic         clk,
    input  logic         rst,
    dds_wave_gen_if.slave bus
);

    localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};
    localparam int PROD_W = OUT_W + AMP_W + 1;

    logic [PHASE_W-1:0] phase_reg;
    logic [PHASE_W-1:0] inc_act_reg;
    logic [1:0]         mode_act_reg;
    logic [OUT_W-1:0]   out_reg;
    logic               wrap_reg;

    logic [PHASE_W:0]          sum;
    logic                      carry;
    logic [OUT_W-1:0]          saw_u;
    logic [OUT_W-1:0]          tri_t;
    logic [OUT_W-1:0]          shape_u;
    logic signed [OUT_W-1:0]   centred;
    logic signed [PROD_W-1:0]  centred_ext;
    logic signed [PROD_W-1:0]  amp_ext;
    logic signed [PROD_W-1:0]  prod;
    logic signed [PROD_W-1:0]  prod_shifted;
    logic [OUT_W-1:0]          scaled;
    logic [OUT_W-1:0]          out_next;
    logic                      prod_unused;

`ifdef DDS_NOISE_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois form, right-shifting; taps 16,14,13,11 -> feedback mask 0xB400
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    logic [15:0] lfsr_reg;
`endif

    // Phase accumulation with an explicit carry bit for wrap detection
    always_comb begin
        sum   = {1'b0, phase_reg} + {1'b0, inc_act_reg};
        carry = sum[PHASE_W];
    end

    // Waveform shaping from the pre-update phase and the latched mode
    always_comb begin
        saw_u = phase_reg[PHASE_W-1 -: OUT_W];
        tri_t = phase_reg[PHASE_W-2 -: OUT_W];
        shape_u = MID;
        case (mode_act_reg)
            2'b00: shape_u = saw_u;
            2'b01: shape_u = phase_reg[PHASE_W-1] ? ~tri_t : tri_t;
            2'b10: shape_u = (saw_u < bus.duty) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
`ifdef DDS_NOISE_EN
            2'b11: shape_u = lfsr_reg[OUT_W-1:0];
`else
            2'b11: shape_u = MID;
`endif
            default: shape_u = MID;
        endcase
    end

    // Amplitude scaling about midscale; the product is kept full width so
    // the arithmetic shift floors exactly and the result can never overflow
    always_comb begin
        centred      = $signed(shape_u - MID);
        centred_ext  = {{(AMP_W+1){centred[OUT_W-1]}}, centred};
        amp_ext      = $signed({{(OUT_W+1){1'b0}}, bus.amplitude});
        prod         = centred_ext * amp_ext;
        prod_shifted = prod >>> AMP_W;
        scaled       = prod_shifted[OUT_W-1:0];
        out_next     = scaled + MID;
        prod_unused  = ^prod_shifted[PROD_W-1:OUT_W];
    end

    // Oscillator state: advances only on sample ticks, wrap is a single-clk pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg    <= '0;
            inc_act_reg  <= '0;
            mode_act_reg <= 2'b00;
            out_reg      <= MID;
            wrap_reg     <= 1'b0;
        end else begin
            wrap_reg <= 1'b0;
            if (bus.sample_tick) begin
                if (!bus.en) begin
                    phase_reg    <= '0;
                    inc_act_reg  <= bus.freq_inc;
                    mode_act_reg <= bus.mode;
                    out_reg      <= MID;
                end else begin
                    phase_reg <= sum[PHASE_W-1:0];
                    out_reg   <= out_next;
                    if (carry) begin
                        wrap_reg <= 1'b1;
                    end
                    // Retune at wrap, or at once if stalled at zero increment
                    if (carry || (inc_act_reg == '0)) begin
                        inc_act_reg  <= bus.freq_inc;
                        mode_act_reg <= bus.mode;
                    end
                end
            end
        end
    end

`ifdef DDS_NOISE_EN
    // Noise source: steps on running ticks, reseeds at wrap so timbre repeats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= LFSR_SEED;
        end else if (bus.sample_tick && bus.en) begin
            if (carry) begin
                lfsr_reg <= LFSR_SEED;
            end else begin
                lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_MASK : 16'h0000);
            end
        end
    end
`endif

    assign bus.out  = out_reg;
    assign bus.wrap = wrap_reg;

endmodule
